single_cycle_mips: RTL and testbench
====================================

# single_cycle_mips

Single-cycle 32-bit MIPS processor core executing a MIPS-I integer subset, one instruction per clock. It contains the program counter, instruction memory, register file, ALU, control decoder and data memory. It is the top level of the CPU design and has no external data ports; benches load programs and inspect state through the fixed internal hierarchy below.

## Interface
- No parameters. Memory depth is fixed: IM 256 words, DM 256 words.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- Required hierarchy for bench access:
  - `PC`: 32-bit register.
  - `Instruction`: 32-bit wire.
  - Instruction memory instance `IM` with array `Mem[0:255]` of 32-bit words.
  - Data memory instance `DM` with array `Mem[0:255]` of 32-bit words.
  - Register file instance `RF` with array `Registers[0:31]` of 32-bit words.

## Operation
- Fetch:
  - `Instruction = IM.Mem[PC[9:2]]`, combinational.
  - PC bits [1:0] and [31:10] are ignored for addressing.
- Decode fields:
  - op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0], target[25:0].
  - Immediates are always sign-extended.
- Supported instructions:
  - R-type (op 0x00): ADD funct 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A. Result goes to rd.
  - ADDI (0x08): rt = rs + sext(imm).
  - LW (0x23): rt = DM.Mem[(rs+sext(imm))[9:2]].
  - SW (0x2B): DM.Mem[(rs+sext(imm))[9:2]] = rt.
  - BEQ (0x04): if rs == rt, PC = PC+4 + (sext(imm)<<2).
  - J (0x02): PC = {PC4[31:28], target, 2'b00}, where PC4 = PC+4.
- Effective address low bits [1:0] are ignored, so unaligned addresses truncate to a word.
- Arithmetic:
  - 32-bit wrap-around; no overflow traps.
  - SLT compares signed and writes 1 or 0.
- Any other opcode, or an R-type with an unlisted funct, is a NOP:
  - no register write, no memory write;
  - PC = PC+4.
- Register $0:
  - reads as 0 at all times;
  - writes to it are discarded.
- Register reads are combinational from `RF.Registers`.
- Next-PC priority: J, then taken BEQ, then PC+4.

## Timing
- Reset asserted (reset=0):
  - PC = 0 immediately, without waiting for a clock edge.
  - No register or memory write occurs.
- Reset does NOT clear RF, IM or DM. Contents preloaded while in reset must survive.
- Each instruction completes in exactly one cycle. On one rising edge:
  - the register-file write, the data-memory write and the PC update occur together;
  - the instruction executed is the one fetched during the preceding cycle.
- The first rising edge after reset deasserts executes `IM.Mem[0]`.
- Read-during-write:
  - reads in a cycle see the pre-edge values;
  - there is no internal forwarding, since none is needed in a single-cycle design.
- LW data path:
  - the DM read is combinational;
  - the value is captured into the RF on the same edge.
- SW: the DM is written on the rising edge; no register write.
- BEQ and J perform no register or memory write.
- PC wraps modulo 2^32. The IM index wraps modulo 256 via PC[9:2].

## Test plan
- R-type, with $1=10, $2=5:
  - ADD $3 gives 15.
  - SUB $4 gives 5.
  - AND $6 gives 0.
  - OR $7 gives 15.
  - SLT $8,$1,$2 gives 0.
  - SLT $8,$2,$1 gives 1.
  - Signed check: SLT with $1=0xFFFFFFFF, $2=1 gives 1.
- I-type:
  - ADDI $9,$1,10 gives 20.
  - ADDI $13,$0,0xDEAD gives 0xFFFFDEAD.
  - ADDI $0,$1,5 leaves $0 = 0.
- Memory, with DM.Mem[4]=0x12345678 and $11=0xABCDEF12:
  - LW $10,8($1) with $1=10 gives $10 = 0x12345678.
  - SW $11,12($1) gives DM.Mem[5] = 0xABCDEF12.
- Branch:
  - BEQ $1,$2,+1 with operands unequal: next PC = PC+4.
  - BEQ $1,$1,+1 at 0x28: next PC = 0x30, and the instruction at 0x2C is never executed, so its destination stays 0.
- Jump:
  - J 0x00000B at PC 0x24: next PC = 0x2C.
  - The instruction at index 10 is skipped.
- Reset:
  - Drive reset low mid-program: PC goes to 0 asynchronously, while RF/DM contents are unchanged.
  - After release, execution restarts at IM.Mem[0] on the next rising edge.

Source files
------------

// File: rtl/single_cycle_mips.sv
`default_nettype none
// ============================================================================
//  Module   : single_cycle_mips
//  Function : Single-cycle MIPS-I integer subset core (IM, RF, ALU, DM, PC).
//  Revision : 1.0  initial release
// ============================================================================

module single_cycle_mips_imem (
  input  wire logic        i_clk,
  input  wire logic        i_we,
  input  wire logic [7:0]  i_waddr,
  input  wire logic [31:0] i_wdata,
  input  wire logic [7:0]  i_raddr,
  output logic      [31:0] o_rdata
);
  logic [31:0] Mem [0:255];

  always_ff @(posedge i_clk) begin
    if (i_we) Mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = Mem[i_raddr];
endmodule

module single_cycle_mips_dmem (
  input  wire logic        i_clk,
  input  wire logic        i_we,
  input  wire logic [7:0]  i_addr,
  input  wire logic [31:0] i_wdata,
  output logic      [31:0] o_rdata
);
  logic [31:0] Mem [0:255];

  always_ff @(posedge i_clk) begin
    if (i_we) Mem[i_addr] <= i_wdata;
  end

  assign o_rdata = Mem[i_addr];
endmodule

module single_cycle_mips_regfile (
  input  wire logic        i_clk,
  input  wire logic        i_we,
  input  wire logic [4:0]  i_ra1,
  input  wire logic [4:0]  i_ra2,
  input  wire logic [4:0]  i_wa,
  input  wire logic [31:0] i_wd,
  output logic      [31:0] o_rd1,
  output logic      [31:0] o_rd2
);
  logic [31:0] Registers [0:31];

  // $0 is hardwired: writes dropped, reads forced to zero
  always_ff @(posedge i_clk) begin
    if (i_we && (i_wa != 5'd0)) Registers[i_wa] <= i_wd;
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : Registers[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : Registers[i_ra2];
endmodule

module single_cycle_mips (
  input wire logic clk,
  input wire logic reset
);
  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  localparam logic [2:0] c_ALU_ADD = 3'd0;
  localparam logic [2:0] c_ALU_SUB = 3'd1;
  localparam logic [2:0] c_ALU_AND = 3'd2;
  localparam logic [2:0] c_ALU_OR  = 3'd3;
  localparam logic [2:0] c_ALU_SLT = 3'd4;

  logic [31:0] PC;
  logic [31:0] Instruction;

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_sext, w_rd1, w_rd2, w_alu_b, w_alu_y, w_dm_rdata, w_wb_data;
  logic [31:0] w_pc4, w_branch_target, w_jump_target, w_next_pc;
  logic [2:0]  w_alu_op;
  logic        w_reg_write, w_mem_write, w_reg_dst, w_alu_imm, w_mem_to_reg;
  logic        w_branch, w_jump;

  assign w_op     = Instruction[31:26];
  assign w_rs     = Instruction[25:21];
  assign w_rt     = Instruction[20:16];
  assign w_rd     = Instruction[15:11];
  assign w_funct  = Instruction[5:0];
  assign w_sext   = {{16{Instruction[15]}}, Instruction[15:0]};

  // IM has no load path in hardware; its contents are preloaded externally
  single_cycle_mips_imem IM (
    .i_clk   (clk),
    .i_we    (1'b0),
    .i_waddr (8'd0),
    .i_wdata (32'd0),
    .i_raddr (PC[9:2]),
    .o_rdata (Instruction)
  );

  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_alu_imm    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_alu_op     = c_ALU_ADD;
    case (w_op)
      c_OP_RTYPE: begin
        w_reg_dst = 1'b1;
        case (w_funct)
          6'h20: begin w_reg_write = 1'b1; w_alu_op = c_ALU_ADD; end
          6'h22: begin w_reg_write = 1'b1; w_alu_op = c_ALU_SUB; end
          6'h24: begin w_reg_write = 1'b1; w_alu_op = c_ALU_AND; end
          6'h25: begin w_reg_write = 1'b1; w_alu_op = c_ALU_OR;  end
          6'h2A: begin w_reg_write = 1'b1; w_alu_op = c_ALU_SLT; end
          default: ;
        endcase
      end
      c_OP_ADDI: begin w_reg_write = 1'b1; w_alu_imm = 1'b1; end
      c_OP_LW:   begin w_reg_write = 1'b1; w_alu_imm = 1'b1; w_mem_to_reg = 1'b1; end
      c_OP_SW:   begin w_mem_write = 1'b1; w_alu_imm = 1'b1; end
      c_OP_BEQ:  w_branch = 1'b1;
      c_OP_J:    w_jump   = 1'b1;
      default: ;
    endcase
  end

  single_cycle_mips_regfile RF (
    .i_clk (clk),
    .i_we  (w_reg_write & reset),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .i_wa  (w_reg_dst ? w_rd : w_rt),
    .i_wd  (w_wb_data),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  assign w_alu_b = w_alu_imm ? w_sext : w_rd2;

  always_comb begin
    w_alu_y = w_rd1 + w_alu_b;
    case (w_alu_op)
      c_ALU_SUB: w_alu_y = w_rd1 - w_alu_b;
      c_ALU_AND: w_alu_y = w_rd1 & w_alu_b;
      c_ALU_OR:  w_alu_y = w_rd1 | w_alu_b;
      c_ALU_SLT: w_alu_y = {31'd0, ($signed(w_rd1) < $signed(w_alu_b))};
      default:   w_alu_y = w_rd1 + w_alu_b;
    endcase
  end

  single_cycle_mips_dmem DM (
    .i_clk   (clk),
    .i_we    (w_mem_write & reset),
    .i_addr  (w_alu_y[9:2]),
    .i_wdata (w_rd2),
    .o_rdata (w_dm_rdata)
  );

  assign w_wb_data = w_mem_to_reg ? w_dm_rdata : w_alu_y;

  assign w_pc4           = PC + 32'd4;
  assign w_branch_target = w_pc4 + {w_sext[29:0], 2'b00};
  assign w_jump_target   = {w_pc4[31:28], Instruction[25:0], 2'b00};
  assign w_next_pc       = w_jump ? w_jump_target :
                           (w_branch && (w_rd1 == w_rd2)) ? w_branch_target : w_pc4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) PC <= 32'd0;
    else        PC <= w_next_pc;
  end
endmodule

`default_nettype wire

// File: tb/tb_single_cycle_mips.sv
`default_nettype none
// ============================================================================
//  Module   : tb_single_cycle_mips
//  Function : Directed program tests for the single-cycle MIPS core.
//  Revision : 1.0  initial release
// ============================================================================
module tb_single_cycle_mips;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  single_cycle_mips dut (.clk(clk), .reset(reset));

  function automatic logic [31:0] f_r(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] f_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  task automatic hold_and_clear();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dut.IM.Mem[i] = 32'd0;
      dut.DM.Mem[i] = 32'd0;
    end
    for (int i = 0; i < 32; i++) dut.RF.Registers[i] = 32'd0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    checks++;
    if (dut.PC !== 32'd0) begin
      errors++; $display("FAIL reset_pc: got %h expected %h", dut.PC, 32'd0);
    end
  endtask

  task automatic test_rtype();
    int          idx [10] = '{3, 4, 6, 7, 8, 12, 16, 17, 1, 2};
    logic [31:0] exp [10] = '{32'd15, 32'd5, 32'd0, 32'd15, 32'd1, 32'hFFFFFFFF,
                              32'd1, 32'd0, 32'd10, 32'd5};
    hold_and_clear();
    dut.RF.Registers[1] = 32'd10;  dut.RF.Registers[2] = 32'd5;
    dut.RF.Registers[6] = 32'h55;  dut.RF.Registers[8] = 32'h55;
    dut.RF.Registers[17] = 32'h55;
    dut.IM.Mem[0] = f_r(1, 2, 3, 6'h20);
    dut.IM.Mem[1] = f_r(1, 2, 4, 6'h22);
    dut.IM.Mem[2] = f_r(1, 2, 6, 6'h24);
    dut.IM.Mem[3] = f_r(1, 2, 7, 6'h25);
    dut.IM.Mem[4] = f_r(1, 2, 8, 6'h2A);
    dut.IM.Mem[5] = f_r(2, 1, 8, 6'h2A);
    dut.IM.Mem[6] = f_i(6'h08, 0, 12, 16'hFFFF);
    dut.IM.Mem[7] = f_i(6'h08, 0, 15, 16'h0001);
    dut.IM.Mem[8] = f_r(12, 15, 16, 6'h2A);
    dut.IM.Mem[9] = f_r(15, 12, 17, 6'h2A);
    release_reset();
    step(5);
    checks++;
    if (dut.RF.Registers[8] !== 32'd0) begin
      errors++; $display("FAIL slt_1_2: got %h expected %h", dut.RF.Registers[8], 32'd0);
    end
    step(5);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (dut.RF.Registers[idx[k]] !== exp[k]) begin
        errors++;
        $display("FAIL rtype_r%0d: got %h expected %h", idx[k], dut.RF.Registers[idx[k]], exp[k]);
      end
    end
    checks++;
    if (dut.PC !== 32'h28) begin
      errors++; $display("FAIL rtype_pc: got %h expected %h", dut.PC, 32'h28);
    end
  endtask

  task automatic test_itype();
    int          idx [5] = '{9, 13, 0, 18, 19};
    logic [31:0] exp [5] = '{32'd20, 32'hFFFFDEAD, 32'd0, 32'd10, 32'd7};
    hold_and_clear();
    dut.RF.Registers[1] = 32'd10;
    dut.IM.Mem[0] = f_i(6'h08, 1, 9, 16'd10);
    dut.IM.Mem[1] = f_i(6'h08, 0, 13, 16'hDEAD);
    dut.IM.Mem[2] = f_i(6'h08, 1, 0, 16'd5);
    dut.IM.Mem[3] = f_r(0, 1, 18, 6'h20);
    dut.IM.Mem[4] = f_i(6'h08, 1, 19, 16'hFFFD);
    release_reset();
    step(5);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (dut.RF.Registers[idx[k]] !== exp[k]) begin
        errors++;
        $display("FAIL itype_r%0d: got %h expected %h", idx[k], dut.RF.Registers[idx[k]], exp[k]);
      end
    end
  endtask

  task automatic test_memory();
    hold_and_clear();
    dut.DM.Mem[4] = 32'h12345678;  dut.DM.Mem[2] = 32'hCAFEF00D;
    dut.RF.Registers[1] = 32'd10;  dut.RF.Registers[11] = 32'hABCDEF12;
    dut.IM.Mem[0] = f_i(6'h23, 1, 10, 16'd8);
    dut.IM.Mem[1] = f_i(6'h2B, 1, 11, 16'd12);
    dut.IM.Mem[2] = f_i(6'h23, 1, 19, 16'd11);
    dut.IM.Mem[3] = f_i(6'h23, 1, 20, 16'hFFFE);
    release_reset();
    step(1);
    checks++;
    if (dut.RF.Registers[10] !== 32'h12345678) begin
      errors++; $display("FAIL lw: got %h expected %h", dut.RF.Registers[10], 32'h12345678);
    end
    step(1);
    checks++;
    if (dut.DM.Mem[5] !== 32'hABCDEF12) begin
      errors++; $display("FAIL sw: got %h expected %h", dut.DM.Mem[5], 32'hABCDEF12);
    end
    step(2);
    checks++;
    if (dut.RF.Registers[19] !== 32'hABCDEF12) begin
      errors++; $display("FAIL lw_unaligned: got %h expected %h", dut.RF.Registers[19], 32'hABCDEF12);
    end
    checks++;
    if (dut.RF.Registers[20] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL lw_negoff: got %h expected %h", dut.RF.Registers[20], 32'hCAFEF00D);
    end
  endtask

  task automatic test_jump();
    logic [31:0] pcs [2] = '{32'h24, 32'h2C};
    hold_and_clear();
    dut.IM.Mem[0]  = f_j(26'd9);
    dut.IM.Mem[9]  = f_j(26'h00000B);
    dut.IM.Mem[10] = f_i(6'h08, 0, 5, 16'h55);
    dut.IM.Mem[11] = f_i(6'h08, 0, 6, 16'h66);
    release_reset();
    for (int k = 0; k < 2; k++) begin
      step(1);
      checks++;
      if (dut.PC !== pcs[k]) begin
        errors++; $display("FAIL jump_pc%0d: got %h expected %h", k, dut.PC, pcs[k]);
      end
    end
    step(1);
    checks++;
    if (dut.RF.Registers[5] !== 32'd0) begin
      errors++; $display("FAIL jump_skip: got %h expected %h", dut.RF.Registers[5], 32'd0);
    end
    checks++;
    if (dut.RF.Registers[6] !== 32'h66) begin
      errors++; $display("FAIL jump_land: got %h expected %h", dut.RF.Registers[6], 32'h66);
    end
  endtask

  task automatic test_branch();
    logic [31:0] pcs [5] = '{32'h4, 32'h28, 32'h30, 32'h34, 32'h0};
    hold_and_clear();
    dut.RF.Registers[1] = 32'd10;  dut.RF.Registers[2] = 32'd5;
    dut.IM.Mem[0]  = f_i(6'h04, 1, 2, 16'd1);
    dut.IM.Mem[1]  = f_j(26'd10);
    dut.IM.Mem[10] = f_i(6'h04, 1, 1, 16'd1);
    dut.IM.Mem[11] = f_i(6'h08, 0, 7, 16'h77);
    dut.IM.Mem[12] = f_i(6'h08, 0, 8, 16'h88);
    dut.IM.Mem[13] = f_i(6'h04, 0, 0, 16'hFFF2);
    release_reset();
    for (int k = 0; k < 5; k++) begin
      step(1);
      checks++;
      if (dut.PC !== pcs[k]) begin
        errors++; $display("FAIL branch_pc%0d: got %h expected %h", k, dut.PC, pcs[k]);
      end
    end
    checks++;
    if (dut.RF.Registers[7] !== 32'd0) begin
      errors++; $display("FAIL branch_skip: got %h expected %h", dut.RF.Registers[7], 32'd0);
    end
    checks++;
    if (dut.RF.Registers[8] !== 32'h88) begin
      errors++; $display("FAIL branch_land: got %h expected %h", dut.RF.Registers[8], 32'h88);
    end
  endtask

  task automatic test_nop();
    hold_and_clear();
    dut.RF.Registers[1] = 32'd10;
    dut.IM.Mem[0] = f_i(6'h3F, 1, 21, 16'd4);
    dut.IM.Mem[1] = f_r(1, 1, 21, 6'h21);
    dut.IM.Mem[2] = f_i(6'h29, 0, 1, 16'd0);
    dut.IM.Mem[3] = f_i(6'h08, 0, 22, 16'd5);
    release_reset();
    step(3);
    checks++;
    if (dut.PC !== 32'hC) begin
      errors++; $display("FAIL nop_pc: got %h expected %h", dut.PC, 32'hC);
    end
    checks++;
    if (dut.RF.Registers[21] !== 32'd0) begin
      errors++; $display("FAIL nop_reg: got %h expected %h", dut.RF.Registers[21], 32'd0);
    end
    checks++;
    if (dut.DM.Mem[0] !== 32'd0) begin
      errors++; $display("FAIL nop_mem: got %h expected %h", dut.DM.Mem[0], 32'd0);
    end
    step(1);
    checks++;
    if (dut.RF.Registers[22] !== 32'd5) begin
      errors++; $display("FAIL nop_after: got %h expected %h", dut.RF.Registers[22], 32'd5);
    end
  endtask

  task automatic test_back_to_back();
    int          idx [5] = '{1, 2, 3, 4, 5};
    logic [31:0] exp [5] = '{32'd3, 32'd6, 32'd3, 32'd3, 32'd9};
    hold_and_clear();
    dut.IM.Mem[0] = f_i(6'h08, 0, 1, 16'd3);
    dut.IM.Mem[1] = f_r(1, 1, 2, 6'h20);
    dut.IM.Mem[2] = f_r(2, 1, 3, 6'h22);
    dut.IM.Mem[3] = f_i(6'h2B, 0, 3, 16'd4);
    dut.IM.Mem[4] = f_i(6'h23, 0, 4, 16'd4);
    dut.IM.Mem[5] = f_r(4, 2, 5, 6'h20);
    release_reset();
    step(6);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (dut.RF.Registers[idx[k]] !== exp[k]) begin
        errors++;
        $display("FAIL b2b_r%0d: got %h expected %h", idx[k], dut.RF.Registers[idx[k]], exp[k]);
      end
    end
    checks++;
    if (dut.DM.Mem[1] !== 32'd3) begin
      errors++; $display("FAIL b2b_mem: got %h expected %h", dut.DM.Mem[1], 32'd3);
    end
  endtask

  task automatic test_reset_mid();
    hold_and_clear();
    dut.IM.Mem[0] = f_i(6'h08, 22, 22, 16'd1);
    dut.IM.Mem[1] = f_i(6'h08, 22, 22, 16'd1);
    dut.IM.Mem[2] = f_i(6'h2B, 0, 22, 16'd0);
    dut.IM.Mem[3] = f_i(6'h08, 22, 22, 16'd1);
    release_reset();
    step(3);
    checks++;
    if (dut.PC !== 32'hC) begin
      errors++; $display("FAIL rst_prepc: got %h expected %h", dut.PC, 32'hC);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dut.PC !== 32'd0) begin
      errors++; $display("FAIL rst_async_pc: got %h expected %h", dut.PC, 32'd0);
    end
    step(3);
    checks++;
    if (dut.RF.Registers[22] !== 32'd2) begin
      errors++; $display("FAIL rst_keep_rf: got %h expected %h", dut.RF.Registers[22], 32'd2);
    end
    checks++;
    if (dut.DM.Mem[0] !== 32'd2) begin
      errors++; $display("FAIL rst_keep_dm: got %h expected %h", dut.DM.Mem[0], 32'd2);
    end
    release_reset();
    step(1);
    checks++;
    if (dut.RF.Registers[22] !== 32'd3) begin
      errors++; $display("FAIL rst_restart: got %h expected %h", dut.RF.Registers[22], 32'd3);
    end
    checks++;
    if (dut.PC !== 32'h4) begin
      errors++; $display("FAIL rst_restart_pc: got %h expected %h", dut.PC, 32'h4);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_memory();
    test_jump();
    test_branch();
    test_nop();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
